// File: rtl/controle_irrigacao.sv
// Irrigation plant controller: debounced sensor inputs, reservoir level supervision,
// hysteretic inlet valve and a timed sprinkler/drip/rest sequencing FSM.
module controle_irrigacao #(
   parameter int DEB_CYC   = 4,
   parameter int SPR_TIME  = 16,
   parameter int DRIP_TIME = 32,
   parameter int REST_TIME = 8,
   parameter int CW        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       H,
   input  logic       M,
   input  logic       L,
   input  logic       Ua,
   input  logic       Us,
   input  logic       T,
   input  logic       Ag,
   output logic       Ve,
   output logic       Bs,
   output logic       Vs,
   output logic       Al,
   output logic       E,
   output logic [1:0] estado
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPRINKLE = 2'd1,
      DRIP     = 2'd2,
      REST     = 2'd3
   } state_t;

   localparam int NIN = 7;
   localparam logic [3:0]    DEB_LAST  = 4'(DEB_CYC - 1);
   localparam logic [CW-1:0] SPR_LAST  = CW'(SPR_TIME - 1);
   localparam logic [CW-1:0] DRIP_LAST = CW'(DRIP_TIME - 1);
   localparam logic [CW-1:0] REST_LAST = CW'(REST_TIME - 1);

   // Bit order of the conditioned input vector: {H, M, L, Ua, Us, T, Ag}
   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1;
   logic [NIN-1:0] sync2;
   logic [NIN-1:0] filt;
   logic [3:0]     deb_cnt [NIN];

   logic f_h, f_m, f_l, f_ua, f_us, f_t, f_ag;
   logic [2:0] level;
   logic lvl_empty, lvl_low, lvl_mid, lvl_full, lvl_fault;

   logic alarm;
   logic fault_flag;
   logic valve;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] timer;

   assign raw = {H, M, L, Ua, Us, T, Ag};

   // A filtered bit only follows its synchronized copy after DEB_CYC consecutive disagreeing cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NIN; i++) begin
            if (sync2[i] != filt[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  filt[i]    <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 4'd1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign {f_h, f_m, f_l, f_ua, f_us, f_t, f_ag} = filt;

   assign level     = {f_h, f_m, f_l};
   assign lvl_empty = (level == 3'b000);
   assign lvl_low   = (level == 3'b001);
   assign lvl_mid   = (level == 3'b011);
   assign lvl_full  = (level == 3'b111);
   assign lvl_fault = ~(lvl_empty | lvl_low | lvl_mid | lvl_full);

   // MID leaves the valve untouched so a filling reservoir does not chatter between LOW and FULL
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm      <= 1'b0;
         fault_flag <= 1'b0;
         valve      <= 1'b0;
      end else begin
         fault_flag <= lvl_fault;
         alarm      <= lvl_fault | lvl_empty;
         if (lvl_fault || lvl_full)
            valve <= 1'b0;
         else if (lvl_empty || lvl_low)
            valve <= 1'b1;
      end
   end

   // Timer restarts on every state change so each phase lasts exactly its configured length
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            timer <= '0;
         else
            timer <= timer + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (alarm || f_us)
               state_next = IDLE;
            else if (f_ua && (f_t || !f_m))
               state_next = DRIP;
            else if (f_ag)
               state_next = SPRINKLE;
         end
         SPRINKLE: begin
            if (alarm || f_us || !f_ag)
               state_next = REST;
            else if (timer == SPR_LAST)
               state_next = REST;
         end
         DRIP: begin
            if (alarm || f_us)
               state_next = REST;
            else if (timer == DRIP_LAST)
               state_next = REST;
         end
         REST: begin
            if (timer == REST_LAST)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign Ve     = valve;
   assign Al     = alarm;
   assign E      = fault_flag;
   assign Bs     = (state == SPRINKLE);
   assign Vs     = (state == DRIP);
   assign estado = state;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao: expectations are queued with the cycle at which
// they must hold and a negedge monitor pops and checks them against the outputs.
module tb_controle_irrigacao;

   logic       clk = 1'b0;
   logic       reset;
   logic       H, M, L, Ua, Us, T, Ag;
   logic       Ve, Bs, Vs, Al, E;
   logic [1:0] estado;

   typedef struct {
      int         cyc;
      string      tag;
      logic [6:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   controle_irrigacao #(
      .DEB_CYC(4), .SPR_TIME(16), .DRIP_TIME(32), .REST_TIME(8), .CW(8)
   ) dut (
      .clk(clk), .reset(reset),
      .H(H), .M(M), .L(L), .Ua(Ua), .Us(Us), .T(T), .Ag(Ag),
      .Ve(Ve), .Bs(Bs), .Vs(Vs), .Al(Al), .E(E), .estado(estado)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output vector layout: {Ve, Bs, Vs, Al, E, estado}
   function automatic logic [6:0] mk(input bit ve, bs, vs, al, e, input logic [1:0] st);
      return {ve, bs, vs, al, e, st};
   endfunction

   task automatic expectAt(input int c, input string tag, input logic [6:0] v);
      exp_t x;
      x.cyc = c;
      x.tag = tag;
      x.exp = v;
      sb.push_back(x);
   endtask

   task automatic applyStimulus(input logic h, m, l, ua, us, t, ag);
      H  = h;
      M  = m;
      L  = l;
      Ua = ua;
      Us = us;
      T  = t;
      Ag = ag;
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) @(negedge clk);
      #2;
   endtask

   task automatic checkOutput(input exp_t x);
      logic [6:0] obs;
      obs = {Ve, Bs, Vs, Al, E, estado};
      checks++;
      assert (obs === x.exp)
      else begin
         errors++;
         $error("[TB] FAIL %s at cycle %0d: observed=%b expected=%b (Ve,Bs,Vs,Al,E,estado)",
                x.tag, cyc, obs, x.exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         x = sb.pop_front();
         checkOutput(x);
      end
   end

   initial begin
      logic [6:0] idle0, spr0, rest0, drip0;
      idle0 = mk(0, 0, 0, 0, 0, 2'd0);
      spr0  = mk(0, 1, 0, 0, 0, 2'd1);
      rest0 = mk(0, 0, 0, 0, 0, 2'd3);
      drip0 = mk(0, 0, 1, 0, 0, 2'd2);

      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectAt(1, "reset_a", 7'b0);
      expectAt(2, "reset_b", 7'b0);

      waitUntil(2);
      reset = 1'b0;
      expectAt(3, "release_empty", mk(1, 0, 0, 1, 0, 2'd0));

      waitUntil(3);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      expectAt(9,  "low_pending", mk(1, 0, 0, 1, 0, 2'd0));
      expectAt(10, "low_settled", mk(1, 0, 0, 0, 0, 2'd0));

      waitUntil(10);
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      expectAt(17, "mid_holds_ve", mk(1, 0, 0, 0, 0, 2'd0));

      waitUntil(17);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      expectAt(23, "full_pending", mk(1, 0, 0, 0, 0, 2'd0));
      expectAt(24, "full_closes",  idle0);

      waitUntil(24);
      applyStimulus(0, 1, 1, 0, 0, 0, 1);
      expectAt(31, "spr_start",    spr0);
      expectAt(46, "spr_last",     spr0);
      expectAt(47, "spr_to_rest",  rest0);
      expectAt(54, "rest_last",    rest0);
      expectAt(55, "rest_to_idle", idle0);
      expectAt(56, "spr_reenter",  spr0);

      waitUntil(56);
      applyStimulus(1, 0, 1, 0, 0, 0, 1);
      expectAt(62, "fault_pending", spr0);
      expectAt(63, "fault_flagged", mk(0, 1, 0, 1, 1, 2'd1));
      expectAt(64, "fault_abort",   mk(0, 0, 0, 1, 1, 2'd3));

      waitUntil(64);
      applyStimulus(0, 1, 1, 1, 0, 1, 1);
      expectAt(71,  "rest_ignores",  rest0);
      expectAt(72,  "rest_done",     idle0);
      expectAt(73,  "drip_start",    drip0);
      expectAt(104, "drip_last",     drip0);
      expectAt(105, "drip_to_rest",  rest0);
      expectAt(112, "drip_rest_end", rest0);
      expectAt(113, "drip_idle",     idle0);
      expectAt(114, "drip_reenter",  drip0);

      waitUntil(114);
      applyStimulus(0, 1, 1, 1, 1, 1, 1);
      expectAt(120, "us_pending",   drip0);
      expectAt(121, "us_abort",     rest0);
      expectAt(128, "us_rest_end",  rest0);
      expectAt(129, "us_idle",      idle0);
      expectAt(134, "us_idle_hold", idle0);

      waitUntil(134);
      applyStimulus(0, 1, 1, 0, 0, 1, 1);
      expectAt(141, "spr_again",     spr0);
      expectAt(146, "spr_timer5",    spr0);
      expectAt(147, "reset_mid_run", 7'b0);

      waitUntil(146);
      reset = 1'b1;
      waitUntil(147);
      reset = 1'b0;
      expectAt(148, "restart_empty",     mk(1, 0, 0, 1, 0, 2'd0));
      expectAt(153, "restart_filtering", mk(1, 0, 0, 1, 0, 2'd0));
      expectAt(154, "restart_mid",       mk(1, 0, 0, 0, 0, 2'd0));
      expectAt(155, "restart_spr",       mk(1, 1, 0, 0, 0, 2'd1));

      waitUntil(157);
      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s: never checked, expected=%b by cycle %0d", x.tag, x.exp, x.cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
